// File: rtl/aes256_keyexp_seq.sv
// AES-256 key-expansion sequencer: drives a single-lane round-key generator through
// 13 quartets, owning the 8-word window and Rcon schedule, and writes 15 round keys.
module aes256_keyexp_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         key_done,
  output logic         key_err,
  output logic         gen_start,
  output logic [31:0]  gen_w0,
  output logic [31:0]  gen_w1,
  output logic [31:0]  gen_w2,
  output logic [31:0]  gen_w3,
  output logic [31:0]  gen_w4,
  output logic [31:0]  gen_w5,
  output logic [31:0]  gen_w6,
  output logic [31:0]  gen_w7,
  output logic [2:0]   gen_rcon_idx,
  output logic         gen_use_rcon,
  input  logic [31:0]  gen_w8,
  input  logic [31:0]  gen_w9,
  input  logic [31:0]  gen_w10,
  input  logic [31:0]  gen_w11,
  input  logic         gen_done,
  output logic         rk_we,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data
);

  typedef enum logic [2:0] {IDLE, WR_RK0, WR_RK1, ISSUE, WAIT, FIN} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [7:0][31:0]    win_q, win_d;
  logic [3:0]          q_q, q_d, q_inc;
  logic [7:0]          tmo_q, tmo_d;
  logic                rk_we_q, rk_we_d;
  logic [3:0]          rk_idx_q, rk_idx_d;
  logic [127:0]        rk_data_q, rk_data_d;
  logic                gen_start_q, gen_start_d;
  logic                use_rcon_q, use_rcon_d;
  logic [2:0]          rcon_idx_q, rcon_idx_d;
  logic                key_done_q, key_done_d;
  logic                key_err_q, key_err_d;
  logic                key_ready_q, key_ready_d;
  logic                busy_q, busy_d;

  assign q_inc = q_q + 4'd1;

  // Outputs are registered, so each branch sets up what the next cycle shows.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    q_d         = q_q;
    tmo_d       = tmo_q;
    rk_we_d     = 1'b0;
    rk_idx_d    = rk_idx_q;
    rk_data_d   = rk_data_q;
    gen_start_d = 1'b0;
    use_rcon_d  = use_rcon_q;
    rcon_idx_d  = rcon_idx_q;
    key_done_d  = 1'b0;
    key_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid && key_ready_q) begin
          for (int i = 0; i < 8; i++) win_d[i] = key_in[255-32*i -: 32];
          q_d       = 4'd0;
          rk_we_d   = 1'b1;
          rk_idx_d  = 4'd0;
          rk_data_d = key_in[255:128];
          state_d   = WR_RK0;
        end
      end
      WR_RK0: begin
        rk_we_d   = 1'b1;
        rk_idx_d  = 4'd1;
        rk_data_d = {win_q[4], win_q[5], win_q[6], win_q[7]};
        state_d   = WR_RK1;
      end
      WR_RK1: begin
        gen_start_d = 1'b1;
        use_rcon_d  = ~q_q[0];
        rcon_idx_d  = q_q[3:1];
        state_d     = ISSUE;
      end
      ISSUE: begin
        tmo_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (gen_done) begin
          win_d     = {gen_w11, gen_w10, gen_w9, gen_w8, win_q[7:4]};
          q_d       = q_inc;
          rk_we_d   = 1'b1;
          rk_idx_d  = q_q + 4'd2;
          rk_data_d = {gen_w8, gen_w9, gen_w10, gen_w11};
          if (q_inc < 4'd13) begin
            gen_start_d = 1'b1;
            use_rcon_d  = ~q_inc[0];
            rcon_idx_d  = q_inc[3:1];
            state_d     = ISSUE;
          end else begin
            state_d = FIN;
          end
        end else if (tmo_q == TMO_LAST) begin
          key_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      FIN: begin
        // First FIN cycle carries the last write; done pulses on the second.
        if (key_done_q) state_d = IDLE;
        else            key_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    key_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      q_q         <= 4'd0;
      tmo_q       <= 8'd0;
      rk_we_q     <= 1'b0;
      rk_idx_q    <= 4'd0;
      rk_data_q   <= '0;
      gen_start_q <= 1'b0;
      use_rcon_q  <= 1'b1;
      rcon_idx_q  <= 3'd0;
      key_done_q  <= 1'b0;
      key_err_q   <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      q_q         <= q_d;
      tmo_q       <= tmo_d;
      rk_we_q     <= rk_we_d;
      rk_idx_q    <= rk_idx_d;
      rk_data_q   <= rk_data_d;
      gen_start_q <= gen_start_d;
      use_rcon_q  <= use_rcon_d;
      rcon_idx_q  <= rcon_idx_d;
      key_done_q  <= key_done_d;
      key_err_q   <= key_err_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign key_ready    = key_ready_q;
  assign busy         = busy_q;
  assign key_done     = key_done_q;
  assign key_err      = key_err_q;
  assign gen_start    = gen_start_q;
  assign gen_use_rcon = use_rcon_q;
  assign gen_rcon_idx = rcon_idx_q;
  assign rk_we        = rk_we_q;
  assign rk_idx       = rk_idx_q;
  assign rk_data      = rk_data_q;
  assign gen_w0 = win_q[0];
  assign gen_w1 = win_q[1];
  assign gen_w2 = win_q[2];
  assign gen_w3 = win_q[3];
  assign gen_w4 = win_q[4];
  assign gen_w5 = win_q[5];
  assign gen_w6 = win_q[6];
  assign gen_w7 = win_q[7];

endmodule

// File: tb/tb_aes256_keyexp_seq.sv
// Bench for aes256_keyexp_seq: quartet generator model with programmable latency,
// full AES-256 key schedule reference, and a write/issue monitor.
module tb_aes256_keyexp_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready, busy, key_done, key_err, gen_start;
  logic [31:0]  gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7;
  logic [2:0]   gen_rcon_idx;
  logic         gen_use_rcon;
  logic [31:0]  gen_w8 = '0, gen_w9 = '0, gen_w10 = '0, gen_w11 = '0;
  logic         gen_done = 1'b0;
  logic         rk_we;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;

  always #5 clk = ~clk;

  aes256_keyexp_seq #(.TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .key_done(key_done), .key_err(key_err),
    .gen_start(gen_start),
    .gen_w0(gen_w0), .gen_w1(gen_w1), .gen_w2(gen_w2), .gen_w3(gen_w3),
    .gen_w4(gen_w4), .gen_w5(gen_w5), .gen_w6(gen_w6), .gen_w7(gen_w7),
    .gen_rcon_idx(gen_rcon_idx), .gen_use_rcon(gen_use_rcon),
    .gen_w8(gen_w8), .gen_w9(gen_w9), .gen_w10(gen_w10), .gen_w11(gen_w11),
    .gen_done(gen_done), .rk_we(rk_we), .rk_idx(rk_idx), .rk_data(rk_data)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, base = 0;
  logic [7:0]  sbox [256];
  logic [31:0] ref_w [60];

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] bb;
    bb = {b, b} << n;
    return bb[15:8];
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction
  function automatic logic [31:0] rotw(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  task automatic compute_ref(input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) ref_w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = ref_w[i-1];
      if (i % 8 == 0) begin
        rc = 8'h01 << (i/8 - 1);
        t  = subw(rotw(t)) ^ {rc, 24'h0};
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      ref_w[i] = ref_w[i-8] ^ t;
    end
  endtask
  function automatic logic [127:0] ref_rk(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction
  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- generator model ----------------
  int  lat_mode = 0, hang_q = -1, gq = 0, gcnt = 0;
  bit  gpend = 0;
  always @(negedge clk) begin
    logic [31:0] t;
    logic [7:0]  rc;
    gen_done = 1'b0;
    if (rst) gpend = 0;
    else begin
      if (gpend) begin
        gcnt--;
        if (gcnt == 0) begin
          gpend = 0;
          t  = gen_w7;
          rc = 8'h01 << gen_rcon_idx;
          t  = gen_use_rcon ? (subw(rotw(t)) ^ {rc, 24'h0}) : subw(t);
          gen_w8   = gen_w0 ^ t;
          gen_w9   = gen_w1 ^ gen_w8;
          gen_w10  = gen_w2 ^ gen_w9;
          gen_w11  = gen_w3 ^ gen_w10;
          gen_done = 1'b1;
        end
      end
      if (gen_start) begin
        if (gq != hang_q) begin
          gpend = 1;
          gcnt  = (lat_mode != 0) ? int'($urandom_range(1, 20)) : 9;
        end
        gq++;
      end
    end
  end

  // ---------------- monitor ----------------
  int           wr_idx[$], wr_cyc[$], iss_idx[$], iss_cyc[$];
  logic [127:0] wr_data[$];
  bit           iss_use[$];
  int           done_cnt, err_cnt, done_cyc, err_cyc, ready_cyc, viol;
  bit           hold;
  logic [255:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int rel;
    rel = cyc - base;
    if (rk_we) begin
      wr_idx.push_back(int'(rk_idx)); wr_data.push_back(rk_data); wr_cyc.push_back(rel);
    end
    if (gen_start) begin
      iss_use.push_back(gen_use_rcon); iss_idx.push_back(int'(gen_rcon_idx)); iss_cyc.push_back(rel);
    end
    if (key_done) begin done_cnt++; done_cyc = rel; end
    if (key_err)  begin err_cnt++;  err_cyc  = rel; end
    if (rel > 0 && key_ready && ready_cyc < 0) ready_cyc = rel;
    if (rk_we || key_err) hold = 0;
    else if (hold && {gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7} !== snap) viol++;
    if (gen_start) begin
      snap = {gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7};
      hold = 1;
    end
  end

  task automatic clear_logs();
    wr_idx.delete(); wr_cyc.delete(); wr_data.delete();
    iss_use.delete(); iss_idx.delete(); iss_cyc.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; ready_cyc = -1;
    viol = 0; hold = 0; gq = 0;
  endtask

  task automatic start_key(input logic [255:0] k);
    int g = 0;
    @(negedge clk);
    while (!key_ready && g < 300) begin @(negedge clk); g++; end
    n_tests++;
    if (key_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_key_ready: got %b want 1", key_ready);
    end
    clear_logs();
    base = cyc;
    key_in = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt == 0 && err_cnt == 0) begin
      n_fail++; $display("FAIL run_timeout: got no done/err within %0d cycles want completion", budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({key_ready, busy, key_done, key_err, gen_start, rk_we} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 100000", {key_ready, busy, key_done, key_err, gen_start, rk_we});
    end
    n_tests++;
    if (rk_idx !== 4'd0 || rk_data !== 128'h0) begin
      n_fail++; $display("FAIL reset_rk: got idx %0d data %h want 0/0", rk_idx, rk_data);
    end
    n_tests++;
    if ({gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7} !== 256'h0) begin
      n_fail++; $display("FAIL reset_window: got nonzero window want 0");
    end
    n_tests++;
    if (gen_rcon_idx !== 3'd0 || gen_use_rcon !== 1'b1) begin
      n_fail++; $display("FAIL reset_rcon: got idx %0d use %b want 0/1", gen_rcon_idx, gen_use_rcon);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips();
    logic [255:0] k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    int exp_c;
    lat_mode = 0; hang_q = -1;
    compute_ref(k);
    start_key(k);
    wait_end(400);
    n_tests++;
    if (wr_idx.size() != 15) begin
      n_fail++; $display("FAIL fips_write_count: got %0d want 15", wr_idx.size());
    end else begin
      n_tests++;
      if (wr_data[0] !== 128'h603deb1015ca71be2b73aef0857d7781) begin
        n_fail++; $display("FAIL fips_rk0: got %h want 603deb1015ca71be2b73aef0857d7781", wr_data[0]);
      end
      n_tests++;
      if (wr_data[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
        n_fail++; $display("FAIL fips_rk2: got %h want 9ba354118e6925afa51a8b5f2067fcde", wr_data[2]);
      end
      n_tests++;
      if (wr_data[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
        n_fail++; $display("FAIL fips_rk14: got %h want fe4890d1e6188d0b046df344706c631e", wr_data[14]);
      end
      for (int r = 0; r < 15; r++) begin
        exp_c = (r < 2) ? r + 1 : 10*r - 7;
        n_tests++;
        if (wr_idx[r] != r || wr_data[r] !== ref_rk(r) || wr_cyc[r] != exp_c) begin
          n_fail++;
          $display("FAIL fips_write%0d: got idx %0d cyc %0d data %h want idx %0d cyc %0d data %h",
                   r, wr_idx[r], wr_cyc[r], wr_data[r], r, exp_c, ref_rk(r));
        end
      end
    end
    n_tests++;
    if (done_cnt != 1 || done_cyc != 134 || err_cnt != 0) begin
      n_fail++; $display("FAIL fips_done: got cnt %0d cyc %0d err %0d want 1/134/0", done_cnt, done_cyc, err_cnt);
    end
    n_tests++;
    if (ready_cyc != 135) begin
      n_fail++; $display("FAIL fips_ready_return: got cyc %0d want 135", ready_cyc);
    end
    n_tests++;
    if (iss_use.size() != 13) begin
      n_fail++; $display("FAIL rcon_issue_count: got %0d want 13", iss_use.size());
    end else begin
      for (int j = 0; j < 13; j++) begin
        n_tests++;
        if (iss_use[j] != (j % 2 == 0) || iss_idx[j] != j / 2) begin
          n_fail++; $display("FAIL rcon_sched%0d: got use %0d idx %0d want use %0d idx %0d",
                             j, iss_use[j], iss_idx[j], (j % 2 == 0), j / 2);
        end
      end
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++; $display("FAIL window_hold: got %0d changed WAIT cycles want 0", viol);
    end
  endtask

  task automatic test_random_latency();
    logic [255:0] k;
    int bad;
    lat_mode = 1; hang_q = -1;
    for (int it = 0; it < 3; it++) begin
      k = rand_key();
      compute_ref(k);
      start_key(k);
      wait_end(700);
      n_tests++;
      if (wr_idx.size() != 15 || done_cnt != 1 || err_cnt != 0) begin
        n_fail++; $display("FAIL rndlat_count%0d: got writes %0d done %0d err %0d want 15/1/0",
                           it, wr_idx.size(), done_cnt, err_cnt);
      end else begin
        bad = 0;
        for (int r = 0; r < 15; r++) if (wr_idx[r] != r || wr_data[r] !== ref_rk(r)) bad++;
        n_tests++;
        if (bad != 0) begin
          n_fail++; $display("FAIL rndlat_keys%0d: got %0d wrong round keys want 0", it, bad);
        end
      end
      n_tests++;
      if (viol != 0) begin
        n_fail++; $display("FAIL rndlat_window%0d: got %0d changes want 0", it, viol);
      end
    end
    lat_mode = 0;
  endtask

  task automatic test_timeout();
    logic [255:0] k;
    int bad;
    k = rand_key();
    compute_ref(k);
    lat_mode = 0; hang_q = 5;
    start_key(k);
    wait_end(400);
    n_tests++;
    if (err_cnt != 1 || done_cnt != 0 || iss_cyc.size() != 6) begin
      n_fail++; $display("FAIL tmo_flags: got err %0d done %0d issues %0d want 1/0/6", err_cnt, done_cnt, iss_cyc.size());
    end else begin
      n_tests++;
      if (err_cyc != iss_cyc[5] + 33) begin
        n_fail++; $display("FAIL tmo_err_cycle: got %0d want %0d", err_cyc, iss_cyc[5] + 33);
      end
    end
    n_tests++;
    if (wr_idx.size() != 7) begin
      n_fail++; $display("FAIL tmo_write_count: got %0d want 7", wr_idx.size());
    end else begin
      bad = 0;
      for (int r = 0; r < 7; r++) if (wr_idx[r] != r || wr_data[r] !== ref_rk(r)) bad++;
      n_tests++;
      if (bad != 0) begin
        n_fail++; $display("FAIL tmo_partial_keys: got %0d wrong want 0", bad);
      end
    end
    hang_q = -1;
    k = rand_key();
    compute_ref(k);
    start_key(k);
    wait_end(400);
    bad = 0;
    if (wr_idx.size() == 15) for (int r = 0; r < 15; r++) if (wr_data[r] !== ref_rk(r)) bad++;
    n_tests++;
    if (wr_idx.size() != 15 || bad != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL tmo_recover: got writes %0d wrong %0d done %0d want 15/0/1", wr_idx.size(), bad, done_cnt);
    end
  endtask

  task automatic test_valid_held();
    logic [255:0] ka, kb;
    logic [127:0] expa [15];
    logic [127:0] expb [15];
    int g = 0, bad = 0;
    ka = rand_key(); kb = rand_key();
    compute_ref(ka); for (int r = 0; r < 15; r++) expa[r] = ref_rk(r);
    compute_ref(kb); for (int r = 0; r < 15; r++) expb[r] = ref_rk(r);
    lat_mode = 0; hang_q = -1;
    @(negedge clk);
    clear_logs();
    base = cyc;
    key_in = ka; key_valid = 1'b1;
    @(negedge clk);
    key_in = kb;
    while (wr_idx.size() < 16 && g < 400) begin @(negedge clk); g++; end
    key_valid = 1'b0;
    g = 0;
    while (done_cnt < 2 && g < 400) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    n_tests++;
    if (wr_idx.size() != 30 || done_cnt != 2) begin
      n_fail++; $display("FAIL held_counts: got writes %0d done %0d want 30/2", wr_idx.size(), done_cnt);
    end else begin
      for (int r = 0; r < 15; r++) if (wr_data[r] !== expa[r] || wr_data[15+r] !== expb[r]) bad++;
      n_tests++;
      if (bad != 0) begin
        n_fail++; $display("FAIL held_keys: got %0d wrong round keys want 0", bad);
      end
      n_tests++;
      if (wr_cyc[15] != 136 || ready_cyc != 135 || done_cyc != 269) begin
        n_fail++; $display("FAIL held_reaccept: got rk0 cyc %0d ready %0d done %0d want 136/135/269",
                           wr_cyc[15], ready_cyc, done_cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    int g = 0, n, bad = 0;
    k = rand_key();
    compute_ref(k);
    lat_mode = 0; hang_q = -1;
    start_key(k);
    while (iss_use.size() < 4 && g < 200) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({key_ready, busy, key_done, key_err, gen_start, rk_we} !== 6'b100000 || rk_idx !== 4'd0 ||
        rk_data !== 128'h0 || gen_rcon_idx !== 3'd0 || gen_use_rcon !== 1'b1 ||
        {gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7} !== 256'h0) begin
      n_fail++; $display("FAIL midrst_values: got flags %b idx %0d rcon %0d/%b want 100000 0 0/1",
                         {key_ready, busy, key_done, key_err, gen_start, rk_we}, rk_idx, gen_rcon_idx, gen_use_rcon);
    end
    rst = 1'b0;
    n = wr_idx.size();
    repeat (40) @(negedge clk);
    n_tests++;
    if (wr_idx.size() != 5 || n != 5 || done_cnt != 0) begin
      n_fail++; $display("FAIL midrst_no_writes: got writes %0d->%0d done %0d want 5->5 0", n, wr_idx.size(), done_cnt);
    end
    k = rand_key();
    compute_ref(k);
    start_key(k);
    wait_end(400);
    if (wr_idx.size() == 15) for (int r = 0; r < 15; r++) if (wr_data[r] !== ref_rk(r)) bad++;
    n_tests++;
    if (wr_idx.size() != 15 || bad != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL midrst_fresh: got writes %0d wrong %0d done %0d want 15/0/1", wr_idx.size(), bad, done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = ginv(8'(i));
      sbox[i] = b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    end
    clear_logs();
    test_reset();
    test_fips();
    test_random_latency();
    test_timeout();
    test_valid_held();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes256_keyexp_seq.md
# aes256_keyexp_seq

Sequencer for the single-lane AES-256 round-key generator (`roundkeygen_1lane`). It accepts a 256-bit cipher key and drives the generator through all 13 quartet expansions. It maintains the 8-word sliding window and the Rcon schedule, and writes the 15 resulting 128-bit round keys into the core's round-key store. It sits between the crypto core's key-load path and the generator and key store, and owns the generator exclusively.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32: maximum number of WAIT cycles for `gen_done` before the run aborts. Legal range 10..255.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in 256: cipher key; `key_in[255:224]` is w[0].
- `key_valid` in 1: key offer.
- `key_ready` out 1: high only in IDLE. A key is accepted when `key_valid && key_ready`.
- `busy` out 1: high in every state except IDLE.
- `key_done` out 1: one-cycle pulse when all 15 round keys have been written.
- `key_err` out 1: one-cycle pulse when the generator times out.
- `gen_start` out 1: one-cycle start pulse to the generator.
- `gen_w0` … `gen_w7` out 32 each: sliding window to the generator.
- `gen_rcon_idx` out 3: Rcon index.
- `gen_use_rcon` out 1: 1 for an i%8==0 quartet, 0 for an i%8==4 quartet.
- `gen_w8` … `gen_w11` in 32 each: generator results, valid while `gen_done` is high.
- `gen_done` in 1: generator completion pulse.
- `rk_we` out 1: round-key write strobe.
- `rk_idx` out 4: round-key index, 0..14.
- `rk_data` out 128: round key, `{w[4r], w[4r+1], w[4r+2], w[4r+3]}`.

## Operation
- FSM states: IDLE, WR_RK0, WR_RK1, ISSUE, WAIT, FIN.
- IDLE
  - On acceptance, register `key_in` into the window: `gen_w0` = w[0] … `gen_w7` = w[7].
  - Clear the quartet counter `q` (4 bits) and go to WR_RK0.
  - `key_valid` is ignored in every other state; no queuing.
- WR_RK0: `rk_we`=1, `rk_idx`=0, `rk_data`={`gen_w0`..`gen_w3`}. Go to WR_RK1.
- WR_RK1: `rk_we`=1, `rk_idx`=1, `rk_data`={`gen_w4`..`gen_w7`}. Go to ISSUE.
- ISSUE
  - `gen_start`=1 for exactly this cycle.
  - `gen_use_rcon` = ~q[0]; `gen_rcon_idx` = q[3:1] (range 0..6).
  - Clear the timeout counter and go to WAIT.
- WAIT
  - Window, `gen_use_rcon` and `gen_rcon_idx` are held stable from ISSUE until the cycle after `gen_done` is seen. The generator samples w0..w3 combinationally at completion, so this hold is required.
  - On `gen_done`, in the next cycle:
    - `rk_we`=1, `rk_idx`=q+2, `rk_data`={`gen_w8`..`gen_w11`}.
    - Window shifts: w0..w3 ← w4..w7, w4..w7 ← `gen_w8`..`gen_w11`.
    - q ← q+1.
    - Next state is ISSUE if the new q < 13, else FIN.
  - The timeout counter increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES` without `gen_done`: pulse `key_err`, no write, go to IDLE. Window contents are don't-care after an abort.
- FIN: `key_done`=1 for one cycle, then go to IDLE.
- `gen_done` outside WAIT is ignored.
- The generator's `rcon_idx_out` and `use_rcon_out` are not consumed; this block is authoritative for the Rcon schedule.

## Timing
- Reset values:
  - State IDLE; `key_ready`=1.
  - `busy`, `key_done`, `key_err`, `gen_start`, `rk_we` = 0.
  - `rk_idx`=0; `rk_data`=0; `gen_w0`..`gen_w7`=0.
  - `gen_rcon_idx`=0; `gen_use_rcon`=1.
- Reset asserted mid-run returns to IDLE next cycle with the reset values and no further writes. The generator is reset by the same reset.
- All outputs are registered; `rk_*` is stable only during `rk_we`.
- Cycle numbering with acceptance at cycle 0:
  - RK0 written at cycle 1, RK1 at cycle 2, first ISSUE at cycle 3.
  - With nominal generator latency (`gen_done` 9 cycles after the `gen_start` cycle), each quartet takes 10 cycles.
  - RK2 is written at cycle 13; RKk is written at cycle 10k−7.
  - RK14 is written at cycle 133, `key_done` pulses at cycle 134, and `key_ready`=1 from cycle 135.
- Any generator latency ≥1 must work, as long as it is below the timeout.

## Test plan
- FIPS-197 A.3 key `603deb10…0914dff4`:
  - RK0 = `603deb1015ca71be2b73aef0857d7781`.
  - RK2 = `9ba354118e6925afa51a8b5f2067fcde`.
  - RK14 = `fe4890d1e6188d0b046df344706c631e`.
  - 15 writes at cycles 1, 2, 13, …, 133; `key_done` at cycle 134.
- Rcon schedule check: across the 13 ISSUE cycles, (`gen_use_rcon`, `gen_rcon_idx`) = (1,0), (0,0), (1,1), (0,1) … (1,6). The window must not change anywhere in WAIT.
- Generator model with random latency 1..20 per quartet: identical round keys to the nominal run, and exactly 15 `rk_we` pulses.
- Generator model that never raises `gen_done` on quartet 5: `key_err` pulses after 32 WAIT cycles, only RK0..RK6 are written, and the next `key_valid` is accepted and completes normally.
- `key_valid` held high throughout a run with a changed `key_in`: no second acceptance until IDLE; the first key's round keys are unaffected.
- `rst` pulsed during WAIT of quartet 3: the next cycle shows all reset values, no `rk_we` follows, and a fresh key then completes correctly.
